serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1..32.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have port A, input, WIDTH bits: first operand, sampled only when START is accepted.
REQ-006 The block SHALL have port B, input, WIDTH bits: second operand, sampled only when START is accepted.
REQ-007 The block SHALL have port CARRY_IN, input, 1 bit: initial carry, sampled only when START is accepted.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-010 The block SHALL have port SUM, output, WIDTH bits: registered result of A+B+CARRY_IN, modulo 2^WIDTH.
REQ-011 The block SHALL have port CARRY_OUT, output, 1 bit: registered carry out of the MSB.

Function
REQ-012 The block SHALL compute with exactly one internal instance of the existing Full_Adder cell (ports X, Y, CARRY_IN, SUM, CARRY_OUT), reused bit-serially LSB first; no wider adder is permitted.
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and FIN.
REQ-014 In IDLE, START=1 at a rising edge SHALL be accepted: A, B and CARRY_IN are captured into operand shift registers and a carry flop, the bit counter is cleared to 0, and the FSM moves to RUN.
REQ-015 In IDLE, START=0 SHALL leave the FSM in IDLE with all registers unchanged.
REQ-016 Each RUN edge SHALL process one bit i:
- Full_Adder X=A[i], Y=B[i], CARRY_IN=carry flop.
- The adder's SUM bit is shifted into the result shift register (MSB in, shift right).
- The adder's CARRY_OUT is written to the carry flop.
- The counter increments.
REQ-017 When the counter equals WIDTH-1, the RUN edge SHALL process the last bit and move the FSM to FIN; RUN therefore lasts exactly WIDTH cycles.
REQ-018 On that final RUN edge, the SUM and CARRY_OUT output registers SHALL load the completed result.
REQ-019 SUM and CARRY_OUT SHALL hold their value from then until the next completion; they SHALL NOT change during RUN.
REQ-020 FIN SHALL last exactly one cycle; DONE SHALL equal 1 only in FIN, and the FSM SHALL then return to IDLE unconditionally.
REQ-021 Latency: if START is accepted at edge k, DONE SHALL be high in the cycle after edge k+WIDTH, and a new START SHALL first be accepted at edge k+WIDTH+2.
REQ-022 BUSY SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-023 START SHALL be ignored in RUN and FIN, and changes to A, B or CARRY_IN after capture SHALL NOT affect the running addition.
REQ-024 With WIDTH=1, RUN SHALL last one cycle and behave identically in all other respects.
REQ-025 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 RST_N=0 SHALL, immediately and independently of CLK, force:
- FSM to IDLE.
- BUSY=0, DONE=0, SUM=0, CARRY_OUT=0.
- Counter, carry flop and all shift registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the addition with no DONE pulse; after reset release, the next accepted START SHALL produce a correct result.
REQ-028 The first edge after RST_N rises SHALL be able to accept START.

Verification (WIDTH=8 unless stated)
REQ-029 A=0x3C, B=0x42, CARRY_IN=0, START pulsed -> DONE high exactly 8 edges after acceptance; SUM=0x7E, CARRY_OUT=0.
REQ-030 A=0xFF, B=0x01, CARRY_IN=0 -> SUM=0x00, CARRY_OUT=1; A=0xA5, B=0x5A, CARRY_IN=1 -> SUM=0x00, CARRY_OUT=1.
REQ-031 START held high continuously with A/B toggling every cycle -> one result per 10 cycles, each matching the operands present at its accepting edge; previous SUM held during RUN.
REQ-032 RST_N pulsed low at RUN cycle 4 of 0xFF+0xFF -> all outputs read 0 at once, no DONE; a following 0x01+0x02 -> SUM=0x03, CARRY_OUT=0.
REQ-033 WIDTH=1, all 8 combinations of A, B, CARRY_IN -> SUM and CARRY_OUT match the full-adder truth table, with DONE one edge after acceptance.
REQ-034 A random loop of at least 1000 operations SHALL be compared against a reference model of {CARRY_OUT, SUM} = A+B+CARRY_IN.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial adder, one Full_Adder reused LSB first to form A+B+CARRY_IN.
// Latency : START accepted at edge k -> DONE high after edge k+WIDTH, next START at edge k+WIDTH+2.
// Backpr. : none; START is ignored while BUSY, so the requester must hold or retry it.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   START, A, B,       request plus operands/carry, captured only on acceptance in IDLE
//   CARRY_IN
//   BUSY, DONE         high in RUN/FIN; one-cycle pulse in FIN
//   SUM, CARRY_OUT     registered result, held until the next completion

module Full_Adder (
  input  logic X,
  input  logic Y,
  input  logic CARRY_IN,
  output logic SUM,
  output logic CARRY_OUT
);
  assign SUM       = X ^ Y ^ CARRY_IN;
  assign CARRY_OUT = (X & Y) | (CARRY_IN & (X ^ Y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CARRY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_OUT
);

  // One extra bit so the post-increment on the final bit (value WIDTH) never wraps.
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             co_q,    co_d;

  logic             fa_sum;
  logic             fa_co;
  logic [WIDTH-1:0] res_shift;

  // The single adder cell always looks at the current LSB of each operand register.
  Full_Adder u_fa (
    .X         (a_q[0]),
    .Y         (b_q[0]),
    .CARRY_IN  (c_q),
    .SUM       (fa_sum),
    .CARRY_OUT (fa_co)
  );

  // Result register fills from the MSB side; after WIDTH shifts bit 0 holds the LSB sum.
  generate
    if (WIDTH > 1) begin : g_shift
      assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
    end else begin : g_bit
      assign res_shift = fa_sum;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          c_d     = CARRY_IN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        // Output registers only move on the last bit, so SUM stays stable during RUN.
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          co_d    = fa_co;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == FIN);
  assign SUM       = sum_q;
  assign CARRY_OUT = co_q;

endmodule
